core_flow_ctrl: RTL and testbench



---
 rtl/core_flow_ctrl_if.sv | 35 +++
 rtl/core_flow_ctrl.sv | 126 ++++++++++++
 tb/tb_core_flow_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/core_flow_ctrl_if.sv
// Request/command bundle between the flow controller and the EX unit, bus
// interfaces, interrupt source and PC generator.
interface core_flow_ctrl_if #(
    parameter int DW = 32
);
    logic          soft_reset_req_i;
    logic          ex_jump_req_i;
    logic [DW-1:0] ex_jump_addr_i;
    logic          irq_req_i;
    logic          ifu_stall_i;
    logic          lsu_stall_i;
    logic          pc_reset_o;
    logic          pc_hold_o;
    logic          pc_jump_o;
    logic [DW-1:0] pc_jump_addr_o;
    logic          hold_if_id_o;
    logic          hold_id_ex_o;
    logic          flush_if_id_o;
    logic          flush_id_ex_o;
    logic          irq_ack_o;

    modport master (
        output soft_reset_req_i, ex_jump_req_i, ex_jump_addr_i, irq_req_i,
               ifu_stall_i, lsu_stall_i,
        input  pc_reset_o, pc_hold_o, pc_jump_o, pc_jump_addr_o, hold_if_id_o,
               hold_id_ex_o, flush_if_id_o, flush_id_ex_o, irq_ack_o
    );

    modport slave (
        input  soft_reset_req_i, ex_jump_req_i, ex_jump_addr_i, irq_req_i,
               ifu_stall_i, lsu_stall_i,
        output pc_reset_o, pc_hold_o, pc_jump_o, pc_jump_addr_o, hold_if_id_o,
               hold_id_ex_o, flush_if_id_o, flush_id_ex_o, irq_ack_o
    );
endinterface

// File: rtl/core_flow_ctrl.sv
// Pipeline flow controller: arbitrates reset, EX jumps, interrupts and bus
// stalls into one PC command plus per-stage hold/flush strobes.
module core_flow_ctrl #(
    parameter int          DW           = 32,
    parameter int          RESET_CYCLES = 4,
    parameter int          DRAIN_CYCLES = 2,
    parameter logic [31:0] IRQ_VEC      = 32'h0000_0100
) (
    input logic              clk_i,
    input logic              rst_i,
    core_flow_ctrl_if.slave  bus
);
    localparam int CMAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {RST, RUN, PEND_JUMP, IRQ_DRAIN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] pend_addr, pend_addr_n;
    logic          stall;

    assign stall = bus.ifu_stall_i | bus.lsu_stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RST;
            cnt       <= CW'(RESET_CYCLES - 1);
            pend_addr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend_addr <= pend_addr_n;
        end
    end

    always_comb begin
        state_n             = state;
        cnt_n               = cnt;
        pend_addr_n         = pend_addr;
        bus.pc_reset_o      = 1'b0;
        bus.pc_hold_o       = 1'b0;
        bus.pc_jump_o       = 1'b0;
        bus.pc_jump_addr_o  = '0;
        bus.hold_if_id_o    = 1'b0;
        bus.hold_id_ex_o    = 1'b0;
        bus.flush_if_id_o   = 1'b0;
        bus.flush_id_ex_o   = 1'b0;
        bus.irq_ack_o       = 1'b0;

        if (bus.soft_reset_req_i) begin
            // Soft reset overrides whatever the current state would issue.
            bus.pc_reset_o    = 1'b1;
            bus.flush_if_id_o = 1'b1;
            bus.flush_id_ex_o = 1'b1;
            state_n           = RST;
            cnt_n             = CW'(RESET_CYCLES - 1);
            pend_addr_n       = '0;
        end else begin
            unique case (state)
                RST: begin
                    bus.pc_reset_o    = 1'b1;
                    bus.flush_if_id_o = 1'b1;
                    bus.flush_id_ex_o = 1'b1;
                    if (cnt == '0) state_n = RUN;
                    else           cnt_n   = cnt - CW'(1);
                end
                RUN, IRQ_DRAIN: begin
                    if (bus.ex_jump_req_i && !stall) begin
                        // Also aborts a drain; a still-pending irq is retaken later.
                        bus.pc_jump_o      = 1'b1;
                        bus.pc_jump_addr_o = bus.ex_jump_addr_i;
                        bus.flush_if_id_o  = 1'b1;
                        bus.flush_id_ex_o  = 1'b1;
                        state_n            = RUN;
                    end else if (bus.ex_jump_req_i) begin
                        bus.pc_hold_o    = 1'b1;
                        bus.hold_if_id_o = 1'b1;
                        bus.hold_id_ex_o = 1'b1;
                        pend_addr_n      = bus.ex_jump_addr_i;
                        state_n          = PEND_JUMP;
                    end else if (stall) begin
                        bus.pc_hold_o    = 1'b1;
                        bus.hold_if_id_o = 1'b1;
                        bus.hold_id_ex_o = 1'b1;
                    end else if (state == RUN) begin
                        if (bus.irq_req_i) begin
                            bus.pc_hold_o     = 1'b1;
                            bus.hold_if_id_o  = 1'b1;
                            bus.flush_id_ex_o = 1'b1;
                            cnt_n             = CW'(DRAIN_CYCLES - 1);
                            state_n           = IRQ_DRAIN;
                        end
                    end else if (cnt == '0) begin
                        bus.pc_jump_o      = 1'b1;
                        bus.pc_jump_addr_o = DW'(IRQ_VEC);
                        bus.irq_ack_o      = 1'b1;
                        bus.flush_if_id_o  = 1'b1;
                        bus.flush_id_ex_o  = 1'b1;
                        state_n            = RUN;
                    end else begin
                        bus.pc_hold_o     = 1'b1;
                        bus.hold_if_id_o  = 1'b1;
                        bus.flush_id_ex_o = 1'b1;
                        cnt_n             = cnt - CW'(1);
                    end
                end
                PEND_JUMP: begin
                    // First latched target wins; later EX jumps are ignored.
                    if (stall) begin
                        bus.pc_hold_o    = 1'b1;
                        bus.hold_if_id_o = 1'b1;
                        bus.hold_id_ex_o = 1'b1;
                    end else begin
                        bus.pc_jump_o      = 1'b1;
                        bus.pc_jump_addr_o = pend_addr;
                        bus.flush_if_id_o  = 1'b1;
                        bus.flush_id_ex_o  = 1'b1;
                        state_n            = RUN;
                    end
                end
                default: state_n = RST;
            endcase
        end
    end
endmodule

// File: tb/tb_core_flow_ctrl.sv
// Directed, table-driven bench for core_flow_ctrl (one table row per cycle).
module tb_core_flow_ctrl;
    localparam logic [7:0] R = 8'h80, H = 8'h40, J = 8'h20, HI = 8'h10,
                           HE = 8'h08, FI = 8'h04, FE = 8'h02, A = 8'h01;
    localparam logic [4:0] S = 5'h10, JR = 5'h08, I = 5'h04, IF = 5'h02, LS = 5'h01;

    typedef struct {
        logic [4:0]  in;
        logic [31:0] addr;
        logic [7:0]  exp;
        logic [31:0] eaddr;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_pass = 0, n_total = 0;
    vec_t tbl[$];

    core_flow_ctrl_if #(.DW(32)) bus ();
    core_flow_ctrl #(.DW(32), .RESET_CYCLES(4), .DRAIN_CYCLES(2), .IRQ_VEC(32'h100))
        dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] flags();
        return {bus.pc_reset_o, bus.pc_hold_o, bus.pc_jump_o, bus.hold_if_id_o,
                bus.hold_id_ex_o, bus.flush_if_id_o, bus.flush_id_ex_o, bus.irq_ack_o};
    endfunction

    task automatic add(input logic [4:0] in, input logic [31:0] addr,
                       input logic [7:0] exp, input logic [31:0] eaddr);
        vec_t v;
        v.in = in; v.addr = addr; v.exp = exp; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [4:0] in, input logic [31:0] addr);
        {bus.soft_reset_req_i, bus.ex_jump_req_i, bus.irq_req_i,
         bus.ifu_stall_i, bus.lsu_stall_i} = in;
        bus.ex_jump_addr_i = addr;
    endtask

    task automatic check(input string name, input logic [7:0] exp, input logic [31:0] eaddr);
        logic [7:0] f;
        logic [2:0] pc_cmd;
        f = flags();
        n_total++;
        if (f === exp) n_pass++;
        else $display("FAIL %s flags got %b want %b", name, f, exp);
        n_total++;
        if (bus.pc_jump_addr_o === eaddr) n_pass++;
        else $display("FAIL %s addr got %h want %h", name, bus.pc_jump_addr_o, eaddr);
        pc_cmd = {bus.pc_reset_o, bus.pc_hold_o, bus.pc_jump_o};
        n_total++;
        if ($countones(pc_cmd) <= 1) n_pass++;
        else $display("FAIL %s pc_excl got %b want onehot0", name, pc_cmd);
    endtask

    initial begin
        // unstalled jump
        add(0, 0, 0, 0);
        add(JR, 32'h40, J|FI|FE, 32'h40);
        add(0, 0, 0, 0);
        // stalled jump, second jump ignored
        add(JR|LS, 32'h80, H|HI|HE, 0);
        add(JR|LS, 32'h90, H|HI|HE, 0);
        add(LS, 0, H|HI|HE, 0);
        add(0, 0, J|FI|FE, 32'h80);
        add(0, 0, 0, 0);
        // irq drain with one stalled cycle: ack on 4th cycle counting acceptance
        add(I, 0, H|HI|FE, 0);
        add(I|IF, 0, H|HI|HE, 0);
        add(I, 0, H|HI|FE, 0);
        add(I, 0, J|FI|FE|A, 32'h100);
        add(0, 0, 0, 0);
        // drain aborted by ex jump, irq retaken
        add(I, 0, H|HI|FE, 0);
        add(I|JR, 32'h200, J|FI|FE, 32'h200);
        add(I, 0, H|HI|FE, 0);
        add(I, 0, H|HI|FE, 0);
        add(I, 0, J|FI|FE|A, 32'h100);
        add(0, 0, 0, 0);
        // stalled ex jump during drain, pending jump beats irq
        add(I, 0, H|HI|FE, 0);
        add(I|JR|LS, 32'h300, H|HI|HE, 0);
        add(I, 0, J|FI|FE, 32'h300);
        add(0, 0, 0, 0);
        // soft reset pulse while pending: jump discarded
        add(JR|LS, 32'hA0, H|HI|HE, 0);
        add(S|LS, 0, R|FI|FE, 0);
        for (int k = 0; k < 4; k++) add(0, 0, R|FI|FE, 0);
        add(0, 0, 0, 0);
        // stall blocks irq acceptance in RUN
        add(I|IF, 0, H|HI|HE, 0);
        add(0, 0, 0, 0);
        // held soft reset keeps reloading cnt
        add(S, 0, R|FI|FE, 0);
        add(S, 0, R|FI|FE, 0);
        for (int k = 0; k < 4; k++) add(0, 0, R|FI|FE, 0);
        add(0, 0, 0, 0);

        drive(0, 0);
        repeat (2) @(posedge clk_i);
        #1 check("rst_hold", R|FI|FE, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2 check($sformatf("rst_rel%0d", k), R|FI|FE, 0);
            @(negedge clk_i);
        end
        foreach (tbl[k]) begin
            drive(tbl[k].in, tbl[k].addr);
            #2 check($sformatf("vec%0d", k), tbl[k].exp, tbl[k].eaddr);
            @(negedge clk_i);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
